ws2812b_frame_controller: RTL and testbench
===========================================

Name: ws2812b_frame_controller

Overview:
- Double-buffered pixel frame store that serves the ws2812b serializer's pixel-fetch interface.
- A host writes BGR888 bytes into the back bank while the serializer reads the front bank.
- A host commit request is deferred to the next frame boundary, then banks swap atomically so no LED chain ever shows a torn frame.
- A global brightness scale is applied on the read path and latched per frame.

Parameters:
- NUMBER_OF_LEDS, 16, LEDs in the chain; each bank holds NUMBER_OF_LEDS*3 bytes (B,G,R per LED, ascending address).
- ADDR_BITS, $clog2(NUMBER_OF_LEDS*3), byte address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  host write strobe
- wr_ready  out  1  back bank accepts writes
- wr_address  in  ADDR_BITS  byte address in back bank
- wr_data  in  8  byte to write
- commit  in  1  one-cycle request to present back bank at next frame boundary
- commit_pending  out  1  commit accepted, swap not yet done
- commit_done  out  1  one-cycle pulse on the swap cycle
- brightness  in  8  global scale, sampled at swap
- pixel_address  in  ADDR_BITS  serializer read address
- pixel_request  in  1  serializer read request
- pixel_ready  out  1  read accepted when high together with pixel_request
- pixel_valid  out  1  read data valid
- pixel_data  out  8  scaled byte
- frame_count  out  16  number of completed frame reads, wraps

Behaviour:
- Reset values:
  - front bank = 0
  - wr_ready=1, commit_pending=0, commit_done=0, pixel_valid=0, pixel_data=0, frame_count=0
  - latched brightness=255
  - RAM contents are not cleared.
- Reset mid-read discards in-flight reads: pixel_valid stays 0 after reset.
- Host writes:
  - A write fires when wr_valid && wr_ready; it writes mem[~front][wr_address] in the same cycle.
  - wr_ready = !commit_pending.
  - Addresses >= NUMBER_OF_LEDS*3 are accepted and dropped.
- Commit:
  - commit while !commit_pending sets commit_pending the next cycle.
  - commit while commit_pending is ignored.
  - commit and wr_valid in the same cycle: the write is accepted (wr_ready still 1) and lands before the swap.
- Read path:
  - pixel_ready is always 1.
  - The pipeline has fixed 2-cycle latency. Accepted read at cycle N: cycle N+1 registers the RAM byte; cycle N+2 asserts pixel_valid=1 with pixel_data = (raw * (bright_latched + 1)) >> 8, using a 16-bit product and the upper byte.
  - brightness 255 is passthrough. brightness 0 gives (raw >> 8), which is always 0.
  - Back-to-back reads sustain 1 byte/cycle.
  - Each read uses the bank selected when it was accepted.
  - Out-of-range pixel_address returns 0.
- Frame boundary:
  - Defined as the cycle an accepted read has pixel_address == NUMBER_OF_LEDS*3-1.
  - On that cycle frame_count increments, wrapping 0xFFFF -> 0.
  - If commit_pending is also set on that cycle, then on the next cycle:
    - front toggles
    - bright_latched <= brightness
    - commit_pending <= 0
    - commit_done pulses for 1 cycle
    - wr_ready returns to 1
  - The last byte of the old frame still comes from the old bank.
- After a swap, the new back bank holds the previously displayed frame. The host must rewrite any bytes it wants changed; no copy-back is performed.
- If commit arrives on the same cycle as a boundary read, the swap waits for the following boundary.
- Internal state machine, bank-control side:
  - IDLE: no commit. On commit -> PENDING.
  - PENDING: writes blocked. On boundary -> SWAP.
  - SWAP: lasts 1 cycle, toggles front, pulses commit_done -> IDLE.
- Storage is two NUMBER_OF_LEDS*3 x 8 synchronous-read RAMs (or one RAM with the bank bit as address MSB).

Test Plan:
- Reset, NUMBER_OF_LEDS=4; read addresses 0..11 back-to-back -> pixel_valid high cycles 2..13 after first request; frame_count goes 0->1 one cycle after address 11 is accepted.
- Write bytes 0x10..0x1B to addresses 0..11, then pulse commit mid-frame -> commit_pending=1, wr_ready=0 until frame end. The current frame still returns the old bank. commit_done pulses the cycle after address 11 is read. The next frame returns 0x10..0x1B.
- wr_valid with commit_pending=1 (address 3, data 0xAA) -> write not accepted; after swap, reading address 3 of the front bank is unchanged.
- brightness=127 set before commit, byte 0xFF -> after swap, pixel_data = 0x7F. brightness=0 -> 0x00. Changing brightness without commit -> no effect.
- commit on the same cycle as the boundary read of address 11 -> no swap this frame; commit_done follows the next frame's address 11.
- Assert reset with 2 reads in flight and commit_pending=1 -> no pixel_valid after reset, commit_pending=0, front bank=0, frame_count=0.

Source files
------------

// File: rtl/ws2812b_frame_controller.sv
// rtl/ws2812b_frame_controller.sv - double-buffered BGR888 frame store with frame-boundary commit and brightness scaling
module ws2812b_frame_controller #(
    parameter int NUMBER_OF_LEDS = 16,
    parameter int ADDR_BITS      = $clog2(NUMBER_OF_LEDS * 3)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_address,
    input  logic [7:0]           wr_data,
    input  logic                 commit,
    output logic                 commit_pending,
    output logic                 commit_done,
    input  logic [7:0]           brightness,
    input  logic [ADDR_BITS-1:0] pixel_address,
    input  logic                 pixel_request,
    output logic                 pixel_ready,
    output logic                 pixel_valid,
    output logic [7:0]           pixel_data,
    output logic [15:0]          frame_count
);

    localparam int BYTES = NUMBER_OF_LEDS * 3;
    localparam logic [ADDR_BITS:0]   BYTES_W   = (ADDR_BITS + 1)'(BYTES);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SWAP
    } state_t;

    state_t      state;
    logic        front;
    logic [7:0]  bright_latched;

    logic [7:0]  bank0 [BYTES];
    logic [7:0]  bank1 [BYTES];

    logic        s1_valid;
    logic [7:0]  s1_raw;
    logic [7:0]  s1_bright;

    logic        wr_in_range;
    logic        rd_in_range;
    logic        write_fire;
    logic        boundary;

    assign wr_ready    = !commit_pending;
    assign pixel_ready = 1'b1;
    assign wr_in_range = {1'b0, wr_address} < BYTES_W;
    assign rd_in_range = {1'b0, pixel_address} < BYTES_W;
    assign write_fire  = wr_valid && wr_ready && wr_in_range;
    assign boundary    = pixel_request && (pixel_address == LAST_ADDR);

    // Host always writes the bank that is not being displayed.
    always_ff @(posedge clock) begin
        if (write_fire) begin
            if (front) begin
                bank0[wr_address] <= wr_data;
            end else begin
                bank1[wr_address] <= wr_data;
            end
        end
    end

    // Stage 1 captures byte and brightness with the bank chosen at acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pixel_request;
        end
        if (pixel_request) begin
            if (!rd_in_range) begin
                s1_raw <= 8'd0;
            end else if (front) begin
                s1_raw <= bank1[pixel_address];
            end else begin
                s1_raw <= bank0[pixel_address];
            end
            s1_bright <= bright_latched;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_data  <= 8'd0;
        end else begin
            pixel_valid <= s1_valid;
            if (s1_valid) begin
                pixel_data <= 8'((16'(s1_raw) * (16'(s1_bright) + 16'd1)) >> 8);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            front          <= 1'b0;
            bright_latched <= 8'd255;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            frame_count    <= 16'd0;
        end else begin
            commit_done <= 1'b0;
            if (boundary) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state)
                ST_IDLE, ST_SWAP: begin
                    if (commit) begin
                        state          <= ST_PENDING;
                        commit_pending <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    if (boundary) begin
                        state          <= ST_SWAP;
                        front          <= ~front;
                        bright_latched <= brightness;
                        commit_pending <= 1'b0;
                        commit_done    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_frame_controller.sv
// tb/tb_ws2812b_frame_controller.sv - scoreboard bench for ws2812b_frame_controller
module tb_ws2812b_frame_controller;

    localparam int LEDS  = 4;
    localparam int BYTES = LEDS * 3;
    localparam int AW    = $clog2(BYTES);

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_address;
    logic [7:0]    wr_data;
    logic          commit;
    logic          commit_pending;
    logic          commit_done;
    logic [7:0]    brightness;
    logic [AW-1:0] pixel_address;
    logic          pixel_request;
    logic          pixel_ready;
    logic          pixel_valid;
    logic [7:0]    pixel_data;
    logic [15:0]   frame_count;

    ws2812b_frame_controller #(.NUMBER_OF_LEDS(LEDS), .ADDR_BITS(AW)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_address(wr_address), .wr_data(wr_data),
        .commit(commit), .commit_pending(commit_pending), .commit_done(commit_done),
        .brightness(brightness),
        .pixel_address(pixel_address), .pixel_request(pixel_request), .pixel_ready(pixel_ready),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ready_at;
        int exp;
    } rd_t;

    rd_t  q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    logic [7:0]  m_mem   [2][16];
    bit          m_known [2][16];
    bit          m_front, m_pending, m_done;
    int          m_bright;
    logic [15:0] m_fc;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic cycle(input bit rst, input bit wv, input int wa, input int wd,
                         input bit cm, input bit rq, input int ra);
        int  e;
        rd_t r;
        reset = rst; wr_valid = wv; wr_address = AW'(wa); wr_data = 8'(wd);
        commit = cm; pixel_request = rq; pixel_address = AW'(ra);
        @(posedge clock);
        edge_n++;
        m_done = 0;
        if (rst) begin
            m_front = 0; m_pending = 0; m_bright = 255; m_fc = 16'd0;
            q.delete();
        end else begin
            if (wv && !m_pending && wa < BYTES) begin
                m_mem[!m_front][wa]   = 8'(wd);
                m_known[!m_front][wa] = 1;
            end
            if (rq) begin
                if (ra >= BYTES) e = 0;
                else if (m_known[m_front][ra]) e = (int'(m_mem[m_front][ra]) * (m_bright + 1)) >> 8;
                else e = -1;
                q.push_back('{edge_n + 1, e});
            end
            if (rq && ra == BYTES - 1) begin
                m_fc = m_fc + 16'd1;
                if (m_pending) begin
                    m_front = !m_front; m_bright = int'(brightness);
                    m_pending = 0; m_done = 1;
                end else if (cm) begin
                    m_pending = 1;
                end
            end else if (cm && !m_pending) begin
                m_pending = 1;
            end
        end
        @(negedge clock);
        check("wr_ready", int'(wr_ready), int'(!m_pending));
        check("pixel_ready", int'(pixel_ready), 1);
        check("commit_pending", int'(commit_pending), int'(m_pending));
        check("commit_done", int'(commit_done), int'(m_done));
        check("frame_count", int'(frame_count), int'(m_fc));
        if (rst) check("reset_pixel_data", int'(pixel_data), 0);
        if (pixel_valid) begin
            if (q.size() == 0) begin
                check("pixel_valid_unexpected", 1, 0);
            end else begin
                r = q.pop_front();
                check("pixel_latency", edge_n, r.ready_at);
                if (r.exp >= 0) check("pixel_data", int'(pixel_data), r.exp);
            end
        end else if (q.size() > 0 && q[0].ready_at <= edge_n) begin
            check("pixel_valid_missing", 0, 1);
            void'(q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_frame(input int commit_at);
        for (int a = 0; a < BYTES; a++) cycle(0, 0, 0, 0, a == commit_at, 1, a);
    endtask

    task automatic write_bytes(input int base, input int step);
        for (int a = 0; a < BYTES; a++) cycle(0, 1, a, (base + a * step) & 8'hFF, 0, 0, 0);
    endtask

    initial begin
        brightness = 8'd255;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Plain frame read from reset, then establish a known front bank.
        read_frame(-1);
        idle(3);
        write_bytes(8'h80, 1);
        read_frame(5);
        read_frame(-1);
        idle(3);
        // Commit mid-frame with a blocked write while pending.
        write_bytes(8'h10, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 3, 8'hAA, 0, 0, 0);
        read_frame(-1);
        read_frame(-1);
        idle(3);
        // Brightness scaling, latched only at swap.
        write_bytes(8'hFF, 0);
        brightness = 8'd127;
        cycle(0, 0, 0, 0, 1, 0, 0);
        read_frame(-1);
        read_frame(-1);
        brightness = 8'd0;
        cycle(0, 0, 0, 0, 1, 0, 0);
        read_frame(-1);
        read_frame(-1);
        write_bytes(8'hC0, 3);
        brightness = 8'd200;
        read_frame(-1);
        brightness = 8'd255;
        cycle(0, 0, 0, 0, 1, 0, 0);
        read_frame(-1);
        read_frame(-1);
        // Commit on the boundary read waits one frame.
        read_frame(BYTES - 1);
        read_frame(-1);
        read_frame(-1);
        idle(3);
        // Out-of-range reads and a dropped out-of-range write.
        for (int a = BYTES; a < 16; a++) cycle(0, (a == 13), a, 8'h55, 0, 1, a);
        idle(3);
        // Reset with reads in flight and a pending commit.
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        read_frame(-1);
        idle(3);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) brightness = 8'($urandom_range(0, 255));
            cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 255),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15));
        end
        idle(4);
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
